// File: rtl/perm_seq_pkg.sv
// Shared types and helpers for the permutation round sequencer.
package perm_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_RUN     = 3'd2,
    S_ADVANCE = 3'd3,
    S_FIN     = 3'd4
  } state_t;

  localparam int ADDR_W_DEF = 7;
  localparam int LINE_W_DEF = 25;
  localparam int RND_W      = 5;

  // True when the given stage is the final stage of the final round.
  function automatic logic is_last_step(input int unsigned stage,
                                        input int unsigned round,
                                        input int unsigned num_stages,
                                        input int unsigned num_rounds);
    return (stage == num_stages - 1) && (round == num_rounds - 1);
  endfunction

endpackage

// File: rtl/perm_round_sequencer_mux.sv
// Selects the active stage's buffer port; address/data live in LAUNCH and RUN, write enable in RUN only.
module perm_stage_port_mux #(
  parameter int NUM_STAGES = 4,
  parameter int ADDR_W     = 7,
  parameter int LINE_W     = 25,
  parameter int SIDX_W     = 2
) (
  input  logic [SIDX_W-1:0]            sel_i,
  input  logic                         launch_i,
  input  logic                         run_i,
  input  logic [NUM_STAGES*ADDR_W-1:0] stage_addr_i,
  input  logic [NUM_STAGES-1:0]        stage_we_i,
  input  logic [NUM_STAGES*LINE_W-1:0] stage_wdata_i,
  output logic [ADDR_W-1:0]            mem_addr_o,
  output logic                         mem_we_o,
  output logic [LINE_W-1:0]            mem_wdata_o
);

  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    if (launch_i || run_i) begin
      mem_addr_o  = stage_addr_i[sel_i*ADDR_W +: ADDR_W];
      mem_wdata_o = stage_wdata_i[sel_i*LINE_W +: LINE_W];
    end
    if (run_i) begin
      mem_we_o = stage_we_i[sel_i];
    end
  end

endmodule

// File: rtl/perm_round_sequencer.sv
// Runs NUM_ROUNDS x NUM_STAGES stage blocks over a ping-pong line buffer, flipping banks per stage.
// Optional RUN watchdog under PERM_SEQ_WATCHDOG_EN; otherwise err is tied low.
module perm_round_sequencer
  import perm_seq_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int NUM_ROUNDS = 24,
  parameter int LINE_W     = LINE_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
`ifdef PERM_SEQ_WATCHDOG_EN
  , parameter int TIMEOUT  = 255
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic [NUM_STAGES-1:0]        stage_start,
  input  logic [NUM_STAGES-1:0]        stage_done,
  input  logic [NUM_STAGES*ADDR_W-1:0] stage_addr,
  input  logic [NUM_STAGES-1:0]        stage_we,
  input  logic [NUM_STAGES*LINE_W-1:0] stage_wdata,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic                         mem_we,
  output logic [LINE_W-1:0]            mem_wdata,
  output logic                         src_bank,
  output logic [RND_W-1:0]             round_idx,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int SIDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  state_t              state_q, state_d;
  logic [SIDX_W-1:0]   stage_idx_q, stage_idx_d;
  logic [RND_W-1:0]    round_idx_q, round_idx_d;
  logic                src_bank_q, src_bank_d;
  logic                last_step;

`ifdef PERM_SEQ_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
`endif

  assign last_step = is_last_step(32'(stage_idx_q), 32'(round_idx_q), NUM_STAGES, NUM_ROUNDS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      stage_idx_q <= '0;
      round_idx_q <= '0;
      src_bank_q  <= 1'b0;
`ifdef PERM_SEQ_WATCHDOG_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      stage_idx_q <= stage_idx_d;
      round_idx_q <= round_idx_d;
      src_bank_q  <= src_bank_d;
`ifdef PERM_SEQ_WATCHDOG_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    stage_idx_d = stage_idx_q;
    round_idx_d = round_idx_q;
    src_bank_d  = src_bank_q;
    stage_start = '0;
    done        = 1'b0;
`ifdef PERM_SEQ_WATCHDOG_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_LAUNCH;
          stage_idx_d = '0;
          round_idx_d = '0;
          src_bank_d  = 1'b0;
`ifdef PERM_SEQ_WATCHDOG_EN
          err_d       = 1'b0;
`endif
        end
      end
      S_LAUNCH: begin
        stage_start[stage_idx_q] = 1'b1;
        state_d = S_RUN;
`ifdef PERM_SEQ_WATCHDOG_EN
        cnt_d   = '0;
`endif
      end
      S_RUN: begin
        // Only the active stage's done bit counts; others are stray.
        if (stage_done[stage_idx_q]) begin
          state_d = last_step ? S_FIN : S_ADVANCE;
        end
`ifdef PERM_SEQ_WATCHDOG_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_ADVANCE: begin
        src_bank_d = ~src_bank_q;
        if (stage_idx_q == SIDX_W'(NUM_STAGES - 1)) begin
          stage_idx_d = '0;
          round_idx_d = round_idx_q + RND_W'(1);
        end else begin
          stage_idx_d = stage_idx_q + SIDX_W'(1);
        end
        state_d = S_LAUNCH;
      end
      S_FIN: begin
        src_bank_d = ~src_bank_q;
        done       = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  perm_stage_port_mux #(
    .NUM_STAGES (NUM_STAGES),
    .ADDR_W     (ADDR_W),
    .LINE_W     (LINE_W),
    .SIDX_W     (SIDX_W)
  ) u_port_mux (
    .sel_i         (stage_idx_q),
    .launch_i      (state_q == S_LAUNCH),
    .run_i         (state_q == S_RUN),
    .stage_addr_i  (stage_addr),
    .stage_we_i    (stage_we),
    .stage_wdata_i (stage_wdata),
    .mem_addr_o    (mem_addr),
    .mem_we_o      (mem_we),
    .mem_wdata_o   (mem_wdata)
  );

  assign src_bank  = src_bank_q;
  assign round_idx = round_idx_q;
  assign busy      = (state_q != S_IDLE);

`ifdef PERM_SEQ_WATCHDOG_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_perm_round_sequencer.sv
// Bench for perm_round_sequencer: timeline model of a 4-stage x 2-round run with fixed-latency stage blocks.
module tb_perm_round_sequencer;
  localparam int S  = 4;
  localparam int R  = 2;
  localparam int N  = 64;
  localparam int P  = N + 2;
  localparam int T  = S * R * P;
  localparam int AW = 7;
  localparam int LW = 25;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [S-1:0]  stage_start, stage_done, stage_we;
  logic [S*AW-1:0] stage_addr;
  logic [S*LW-1:0] stage_wdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [LW-1:0] mem_wdata;
  logic          src_bank;
  logic [4:0]    round_idx;
  logic          busy, done, err;

  perm_round_sequencer #(.NUM_STAGES(S), .NUM_ROUNDS(R)) dut (
    .clk(clk), .rst(rst), .start(start),
    .stage_start(stage_start), .stage_done(stage_done),
    .stage_addr(stage_addr), .stage_we(stage_we), .stage_wdata(stage_wdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .src_bank(src_bank), .round_idx(round_idx),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  logic [AW-1:0] lane_addr [S];
  logic [LW-1:0] lane_wdata [S];
  logic          lane_we [S];
  int  launch_cyc [S];
  bit  hang = 1'b0;
  bit  chk_en = 1'b0;

  bit  run_on = 1'b0;
  int  run_c0 = 0;
  int  idle_round = 0;
  int  order_q [$];
  int  done_cyc = -1;
  int  busy_cnt = 0;
  int  c0 = 0;

  int  m_t, m_k, m_ph, m_ln;
  bit  m_act;
  logic [S-1:0]  e_start;
  logic          e_busy, e_done, e_bank, e_we;
  logic [4:0]    e_round;
  logic [AW-1:0] e_addr;
  logic [LW-1:0] e_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // Advance one cycle, then drive lanes and the fixed-latency stage model.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < S; i++) begin
      if (i == 2) begin
        lane_addr[i]  = 7'h15;
        lane_wdata[i] = 25'h1ABCDEF;
        lane_we[i]    = 1'b1;
      end else begin
        lane_addr[i]  = AW'($urandom);
        lane_wdata[i] = LW'($urandom);
        lane_we[i]    = 1'($urandom);
      end
      stage_addr[i*AW +: AW]  = lane_addr[i];
      stage_wdata[i*LW +: LW] = lane_wdata[i];
      stage_we[i]             = lane_we[i];
      stage_done[i]           = !hang && (launch_cyc[i] + N == cyc);
    end
  endtask

  // Timeline model: a run is S*R periods of P cycles, starting the cycle after start is sampled.
  always @(negedge clk) begin
    if (chk_en) begin
      m_t   = cyc - run_c0;
      m_act = run_on && (m_t >= 1) && (m_t <= T);
      if (m_act) begin
        m_k     = (m_t - 1) / P;
        m_ph    = (m_t - 1) % P;
        m_ln    = m_k % S;
        e_start = (m_ph == 0) ? S'(1 << m_ln) : '0;
        e_busy  = 1'b1;
        e_done  = (m_t == T);
        e_bank  = 1'(m_k % 2);
        e_round = 5'(m_k / S);
        e_addr  = (m_ph <= N) ? lane_addr[m_ln] : '0;
        e_wdata = (m_ph <= N) ? lane_wdata[m_ln] : '0;
        e_we    = (m_ph >= 1 && m_ph <= N) ? lane_we[m_ln] : 1'b0;
      end else begin
        e_start = '0;
        e_busy  = 1'b0;
        e_done  = 1'b0;
        e_bank  = 1'b0;
        e_round = 5'(idle_round);
        e_addr  = '0;
        e_wdata = '0;
        e_we    = 1'b0;
      end
      chk("stage_start", 32'(stage_start), 32'(e_start));
      chk("busy",        32'(busy),        32'(e_busy));
      chk("done",        32'(done),        32'(e_done));
      chk("src_bank",    32'(src_bank),    32'(e_bank));
      chk("round_idx",   32'(round_idx),   32'(e_round));
      chk("mem_addr",    32'(mem_addr),    32'(e_addr));
      chk("mem_wdata",   32'(mem_wdata),   32'(e_wdata));
      chk("mem_we",      32'(mem_we),      32'(e_we));
      chk("err",         32'(err),         32'd0);
      if (m_act && m_t == T) begin
        run_on     = 1'b0;
        idle_round = R - 1;
      end
      if (rst) begin
        run_on     = 1'b0;
        idle_round = 0;
      end else if (start && !m_act) begin
        run_on = 1'b1;
        run_c0 = cyc;
      end
    end
    for (int i = 0; i < S; i++) begin
      if (rst) launch_cyc[i] = -1000;
      else if (stage_start[i]) begin
        launch_cyc[i] = cyc;
        order_q.push_back(i);
      end
    end
    if (busy) busy_cnt++;
    if (done) done_cyc = cyc;
  end

`ifdef PERM_SEQ_WATCHDOG_EN
  int  t_err = -1;
  bit  saw_done = 1'b0;
`endif

  initial begin
    rst = 1'b1; start = 1'b0;
    stage_done = '0; stage_we = '0; stage_addr = '0; stage_wdata = '0;
    for (int i = 0; i < S; i++) begin
      launch_cyc[i] = -1000;
      lane_addr[i] = '0; lane_wdata[i] = '0; lane_we[i] = 1'b0;
    end
    tick();
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_outputs", 32'({busy, done, src_bank, round_idx, mem_we, stage_start, err, mem_addr}), 32'd0);
    tick();
    rst = 1'b0;

    // Run 1: full run with a stray done, a done during LAUNCH and a start while busy.
    order_q.delete(); busy_cnt = 0; done_cyc = -1;
    tick(); start = 1'b1; c0 = cyc;
    for (int t = 1; t <= 540; t++) begin
      tick();
      start = (t == 100);
      if (t == 1 + P + 10)    stage_done = stage_done | 4'b1000;
      if (t == 1 + 2*P)       stage_done = stage_done | 4'b0100;
      if (t == 1 + P + 11) begin
        @(negedge clk);
        chk("spur_bank",  32'(src_bank),  32'd1);
        chk("spur_round", 32'(round_idx), 32'd0);
      end else if (t == 1 + 2*P) begin
        @(negedge clk);
        chk("launch_start", 32'(stage_start), 32'h4);
        chk("launch_we",    32'(mem_we),      32'd0);
      end else if (t == 1 + 2*P + 5) begin
        @(negedge clk);
        chk("mux_addr",  32'(mem_addr),  32'h15);
        chk("mux_wdata", 32'(mem_wdata), 32'h1ABCDEF);
        chk("mux_we",    32'(mem_we),    32'd1);
      end else if (t == 1 + 2*P + N + 1) begin
        @(negedge clk);
        chk("advance_we", 32'(mem_we), 32'd0);
      end
    end
    chk("done_cycle",  32'(done_cyc - c0), 32'd528);
    chk("busy_cycles", 32'(busy_cnt),      32'd528);
    chk("order_len",   32'(order_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < order_q.size(); i++)
      chk("order", 32'(order_q[i]), 32'(i % 4));
    @(negedge clk);
    chk("final_bank", 32'(src_bank), 32'd0);

    // Run 2: reset coincident with the active stage's done, then a fresh run.
    tick(); start = 1'b1; c0 = cyc;
    for (int t = 1; t <= 200; t++) begin
      tick();
      start = 1'b0;
      if (t == 200) begin
        rst = 1'b1;
        stage_done = stage_done | 4'b1000;
      end
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_outputs", 32'({busy, done, src_bank, round_idx, mem_we, stage_start, mem_addr}), 32'd0);
    order_q.delete(); busy_cnt = 0; done_cyc = -1;
    tick(); start = 1'b1; c0 = cyc;
    for (int t = 1; t <= 535; t++) begin
      tick();
      start = 1'b0;
    end
    chk("rerun_done_cycle", 32'(done_cyc - c0), 32'd528);
    chk("rerun_first",      32'(order_q.size() > 0 ? order_q[0] : -1), 32'd0);
    chk("rerun_busy",       32'(busy_cnt), 32'd528);

`ifdef PERM_SEQ_WATCHDOG_EN
    chk_en = 1'b0;
    hang = 1'b1;
    tick(); start = 1'b1; c0 = cyc;
    tick(); start = 1'b0;
    for (int t = 0; t < 400 && t_err < 0; t++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
      if (err) begin
        t_err = cyc - c0;
        chk("wd_busy_drop", 32'(busy), 32'd0);
      end
      tick();
    end
    chk("wd_fired",   32'(t_err >= 250 && t_err <= 260), 32'd1);
    chk("wd_no_done", 32'(saw_done), 32'd0);
    hang = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("wd_err_clear", 32'(err),  32'd0);
    chk("wd_restart",   32'(busy), 32'd1);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL tb_timeout: simulation exceeded time budget");
    $fatal(1, "time budget expired");
  end

endmodule

// File: doc/perm_round_sequencer.md
Name: perm_round_sequencer

Overview:
- Sequences the encoder's stage function blocks (same start/done, 25-bit line, 7-bit count interface as the permutation function) across NUM_ROUNDS rounds of NUM_STAGES stages.
- Owns the shared ping-pong line buffer: routes the active stage's address, write enable and write data to it, and flips the source bank after every stage.
- Sits between the top-level controller (start/done) and the stage blocks.

Parameters:
- NUM_STAGES, 4, stage blocks per round
- NUM_ROUNDS, 24, rounds per run
- LINE_W, 25, line width
- ADDR_W, 7, stage count/address width
- TIMEOUT, 255, max RUN cycles per stage (only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  run request, sampled in IDLE only
- stage_start  out  NUM_STAGES  one-hot one-cycle launch pulse
- stage_done  in  NUM_STAGES  per-stage completion pulse
- stage_addr  in  NUM_STAGES*ADDR_W  flattened stage count values
- stage_we  in  NUM_STAGES  stage write enables
- stage_wdata  in  NUM_STAGES*LINE_W  flattened stage write values
- mem_addr  out  ADDR_W  shared buffer address
- mem_we  out  1  shared buffer write enable
- mem_wdata  out  LINE_W  shared buffer write data
- src_bank  out  1  bank the active stage reads; it writes ~src_bank
- round_idx  out  5  current round (iota constant select)
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at run completion
- err  out  1  watchdog flag (0 when the feature is compiled out)

Behaviour:
- Clock is clk; reset is synchronous and active-high on rst.
- Reset: state IDLE, stage_idx=0, round_idx=0, src_bank=0. All outputs 0.
- rst mid-run aborts immediately; rst has priority over coincident start/stage_done.
- FSM states: IDLE, LAUNCH, RUN, ADVANCE, FIN.
- IDLE: on start -> LAUNCH, clearing stage_idx, round_idx and src_bank.
- LAUNCH: stage_start[stage_idx]=1 for exactly one cycle -> RUN. A stage_done seen in LAUNCH is ignored.
- RUN: wait for stage_done[stage_idx]. Done on any other bit is ignored.
  - On done of the last stage of the last round -> FIN.
  - On any other done -> ADVANCE.
- ADVANCE: src_bank toggles. stage_idx increments; on reaching NUM_STAGES-1 it wraps to 0 and round_idx increments. -> LAUNCH.
- FIN: src_bank toggles, done=1 for one cycle -> IDLE. After FIN, src_bank names the bank holding the result.
- Mux: in LAUNCH/RUN, mem_addr and mem_wdata are the stage_idx slices. mem_we = stage_we[stage_idx] only in RUN; 0 in every other state.
- All mux outputs are combinational from registered state. busy is combinational (state != IDLE).
- start while busy is ignored. No queueing.
- Latency: with each stage asserting done N cycles after its start pulse, each stage period is N+2 cycles. done fires (S*R-1)*(N+2)+N+2 cycles after the start sample.

Optional Feature:
- Macro: PERM_SEQ_WATCHDOG_EN.
- Defined:
  - A cycle counter clears on LAUNCH and counts in RUN.
  - Reaching TIMEOUT without the expected done -> err=1 and FSM to IDLE; done is not asserted.
  - err is sticky until rst or the next accepted start.
- Undefined: RUN waits indefinitely; err is tied 0.

Decomposition:
- Package perm_seq_pkg holds:
  - state enum encoding
  - ADDR_W and LINE_W defaults
  - round index width
  - the final-stage/final-round compare helper
- One sub-module, perm_stage_port_mux: purely combinational selection of addr/we/wdata by stage_idx, gated by the RUN/LAUNCH qualifiers.

Test Plan:
- S=4, R=2, stage model done N=64 cycles after start; start at cycle 0 -> stage_start order 0,1,2,3,0,1,2,3; done pulse at cycle 528; busy high cycles 1..528; final src_bank=0.
- Stage 2 active, stage_we[2]=1, addr=0x15, wdata=0x1ABCDEF; stage 1 drives garbage -> mem_addr=0x15, mem_wdata=0x1ABCDEF, mem_we=1; mem_we=0 during LAUNCH/ADVANCE.
- Spurious stage_done[3] while stage 1 in RUN -> ignored; stage_idx stays 1; no bank toggle.
- start pulsed at cycle 100 mid-run -> no effect; run completes at cycle 528 as above.
- rst asserted at cycle 200 coincident with stage_done -> next cycle all outputs 0, IDLE; fresh start reruns from round 0.
- PERM_SEQ_WATCHDOG_EN with TIMEOUT=255, stage 0 never completes -> err=1 at RUN cycle 255, done stays 0, busy drops; next start clears err.
